// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg
// Shared constants for the instruction prefetch slice: default bus widths,
// queue depth, the PC step between sequential fetches, and the logic levels
// used for reset and enables.
package if_prefetch_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    // Sequential instructions are one 32-bit word apart.
    localparam int PC_STEP = 4;

    localparam logic RST_ACTIVE = 1'b1;
    localparam logic EN_ACTIVE  = 1'b1;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Circular queue of fetched {pc, inst} entries with flush.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write one entry at the write pointer
//   pop           drop the head entry
//   flush         empty the queue; takes priority over push/pop
//   rdata         head entry (don't-care when count is zero)
//   count         current occupancy, 0..DEPTH
module fetch_fifo
    import if_prefetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage carries no reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch
// Instruction fetch front end: issues sequential ROM reads, buffers the
// returned words with their PCs, and hands them to decode in order.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   rom_addr_o, rom_ce_o           ROM request (data returns next cycle)
//   rom_data_i                     ROM read data
//   id_valid_o, id_ready_i         head-of-queue handshake to decode
//   id_pc_o, id_inst_o             head entry
//   redirect_i, redirect_pc_i      flush and restart fetch at a new PC
//   count_o                        queue occupancy
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    input  logic              id_ready_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [CW-1:0]     count_o
);

    localparam int WIDTH = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [CW:0]       credit_used;
    logic              credit_ok;
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  head;

    // A request is only issued if its data is guaranteed a queue slot:
    // queued entries plus the one still in flight must leave room.
    assign credit_used = {1'b0, count_o} + (CW+1)'(inflight);
    assign credit_ok   = (rst != RST_ACTIVE) && !redirect_i
                         && (credit_used < (CW+1)'(DEPTH));
    assign rom_ce_o    = credit_ok ? EN_ACTIVE : ~EN_ACTIVE;
    assign rom_addr_o  = fetch_pc;

    // Fetch pointer and in-flight tracking; a redirect drops the pending
    // read so the word returning next cycle is never queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
            inflight <= 1'b0;
        end else if (rom_ce_o == EN_ACTIVE) begin
            fetch_pc    <= fetch_pc + ADDR_W'(PC_STEP);
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    assign push       = inflight && !redirect_i;
    assign id_valid_o = (count_o != '0) && !redirect_i;
    assign pop        = id_valid_o && id_ready_i;

    fetch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata ({inflight_pc, rom_data_i}),
        .rdata (head),
        .count (count_o)
    );

    assign id_pc_o   = head[WIDTH-1:DATA_W];
    assign id_inst_o = head[DATA_W-1:0];

endmodule
